// File: rtl/apb_pkg.sv
// Shared APB types and default bus widths for the manager and subordinate blocks.
package apb_pkg;

  localparam int unsigned APB_DATA_WIDTH = 8;
  localparam int unsigned APB_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_manager_if.sv
// Command/response handshake plus APB bus signals seen by the manager.
interface apb_manager_if
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  // Manager view: accepts commands, drives the APB request side.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // Environment view: issues commands and plays the subordinate.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface : apb_manager_if

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles without PREADY and flags the cycle in which the limit is reached.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // Wait-cycle counter; saturates once the limit is hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Expires during the TIMEOUT-th waiting cycle so the abort edge ends exactly TIMEOUT cycles.
  assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule : apb_wait_timer

// File: rtl/apb_manager.sv
// APB manager: turns a valid/ready command into one SETUP/ACCESS transfer with timeout.
module apb_manager
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_manager_if.master bus
);

  apb_state_e state_q, state_d;

  logic                  cmd_ready_c;
  logic                  accept_c;
  logic                  timer_clear_c;
  logic                  timer_en_c;
  logic                  timer_expired_c;
  logic                  complete_c;
  logic                  abort_c;

  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  assign cmd_ready_c = (state_q == IDLE);
  assign accept_c    = bus.cmd_valid && cmd_ready_c;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (timer_clear_c),
    .enable  (timer_en_c),
    .expired (timer_expired_c)
  );

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; PREADY takes priority over timer expiry in ACCESS.
  always_comb begin
    state_d       = state_q;
    timer_clear_c = 1'b0;
    timer_en_c    = 1'b0;
    complete_c    = 1'b0;
    abort_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) state_d = SETUP;
      end
      SETUP: begin
        timer_clear_c = 1'b1;
        state_d       = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          complete_c = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_en_c = 1'b1;
          if (timer_expired_c) begin
            abort_c = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // APB select/enable follow the next state so they change with the state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
    end
  end

  // Request fields captured on the handshake and held until the next one.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept_c) begin
      pwrite_q <= bus.cmd_write;
      paddr_q  <= bus.cmd_addr;
      pwdata_q <= bus.cmd_wdata;
    end
  end

  // Completion pulse; data and error hold until the next completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= complete_c || abort_c;
      if (complete_c) begin
        rsp_err_q   <= bus.PSLVERR;
        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
      end else if (abort_c) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule : apb_manager

// File: tb/tb_apb_manager.sv
// Directed bench for apb_manager: vector table of single transfers plus reset and back-to-back sequences.
module tb_apb_manager;

  logic PCLK;
  logic PRESETn;

  apb_manager_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

  apb_manager #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (10),
    .TIMEOUT    (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic       write;
    logic [9:0] addr;
    logic [7:0] wdata;
    int         wait_cyc;
    logic [7:0] prdata;
    logic       slverr;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  int passed = 0;
  int total  = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // One command through the manager with a subordinate that waits wait_cyc ACCESS cycles.
  task automatic run_txn(input vec_t v);
    int cyc, acc, sel_cnt, en_cnt;
    bit done, bad_bus;
    cyc = 0; acc = 0; sel_cnt = 0; en_cnt = 0; done = 0; bad_bus = 0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.PREADY    = 1'b0;
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_write = ~v.write;
    while (!done && cyc < 64) begin
      @(negedge PCLK);
      cyc++;
      if (bus.rsp_valid) begin
        done = 1;
      end else begin
        if (bus.PSELx) begin
          sel_cnt++;
          if (bus.PADDR !== v.addr || bus.PWRITE !== v.write || (v.write && bus.PWDATA !== v.wdata))
            bad_bus = 1;
        end
        if (bus.PSELx && bus.PENABLE) begin
          en_cnt++;
          bus.PREADY  = (acc == v.wait_cyc);
          bus.PRDATA  = (acc == v.wait_cyc) ? v.prdata : 8'h00;
          bus.PSLVERR = (acc == v.wait_cyc) ? v.slverr : 1'b0;
          acc++;
        end else if (bus.PSELx) begin
          // SETUP must ignore these
          bus.PREADY  = 1'b1;
          bus.PRDATA  = 8'hFF;
          bus.PSLVERR = 1'b1;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'b0;
        end
      end
    end
    chk({v.name, " rsp_seen"}, 32'(done), 32'd1);
    chk({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({v.name, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    chk({v.name, " rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({v.name, " psel_cycles"}, 32'(sel_cnt), 32'(v.exp_lat - 1));
    chk({v.name, " penable_cycles"}, 32'(en_cnt), 32'(v.exp_lat - 2));
    chk({v.name, " bus_stable"}, 32'(bad_bus), 32'd0);
    chk({v.name, " idle_at_rsp"}, {30'd0, bus.PSELx, bus.cmd_ready}, 32'd1);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 8'h00;
    @(negedge PCLK);
    chk({v.name, " rsp_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    chk({v.name, " rsp_hold"}, {23'd0, bus.rsp_err, bus.rsp_rdata}, {23'd0, v.exp_err, v.exp_rdata});
    chk({v.name, " paddr_hold"}, 32'(bus.PADDR), 32'(v.addr));
  endtask

  vec_t vecs[6];
  logic [9:0] addrs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n_rsp, cur;
    bit hs, overlap, bad_addr, spurious;

    vecs[0] = '{"wr_155",   1'b1, 10'h155, 8'hA5, 0,  8'hEE, 1'b0, 8'h00, 1'b0, 3};
    vecs[1] = '{"rd_3ff",   1'b0, 10'h3FF, 8'h00, 3,  8'h5A, 1'b0, 8'h5A, 1'b0, 6};
    vecs[2] = '{"wr_err",   1'b1, 10'h0F0, 8'h3C, 1,  8'h99, 1'b1, 8'h00, 1'b1, 4};
    vecs[3] = '{"rd_tmo",   1'b0, 10'h000, 8'h00, 99, 8'h77, 1'b0, 8'h00, 1'b1, 18};
    vecs[4] = '{"rd_edge",  1'b0, 10'h2AA, 8'h00, 15, 8'hC3, 1'b0, 8'hC3, 1'b0, 18};
    vecs[5] = '{"rd_err",   1'b0, 10'h001, 8'h00, 0,  8'h81, 1'b1, 8'h81, 1'b1, 3};

    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    #1;
    chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset bus", {26'd0, bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, 1'b0},
        32'd0);
    chk("reset data", {4'd0, bus.PADDR, bus.PWDATA, bus.rsp_rdata}, 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in the middle of a read's ACCESS phase
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 10'h0AA;
    @(posedge PCLK);
    #1 bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mid in_access", {30'd0, bus.PSELx, bus.PENABLE}, 32'd3);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid async_drop", {29'd0, bus.PSELx, bus.PENABLE, bus.rsp_valid}, 32'd0);
    chk("rst_mid cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_mid rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    @(negedge PCLK);
    PRESETn  = 1'b1;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      if (bus.rsp_valid || bus.PSELx) spurious = 1;
    end
    chk("rst_mid no_rsp", 32'(spurious), 32'd0);
    run_txn(vecs[1]);

    // Four commands offered back to back with cmd_valid held high
    addrs[0] = 10'h011; addrs[1] = 10'h122; addrs[2] = 10'h233; addrs[3] = 10'h344;
    idx = 0; n_rsp = 0; cur = 0; overlap = 0; bad_addr = 0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = addrs[0];
    bus.PREADY    = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 4; c++) begin
      hs = bus.cmd_valid && bus.cmd_ready;
      @(negedge PCLK);
      if (hs) begin
        cur = idx;
        idx++;
        if (idx < 4) bus.cmd_addr = addrs[idx];
        else bus.cmd_valid = 1'b0;
      end
      if (bus.rsp_valid) begin
        chk($sformatf("b2b rsp%0d rdata", n_rsp), 32'(bus.rsp_rdata),
            32'(addrs[n_rsp][7:0] ^ 8'h3C));
        n_rsp++;
      end
      if (bus.PSELx) begin
        bus.PRDATA = bus.PADDR[7:0] ^ 8'h3C;
        if (bus.PADDR !== addrs[cur]) bad_addr = 1;
        if (bus.cmd_ready) overlap = 1;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    chk("b2b rsp_count", 32'(n_rsp), 32'd4);
    chk("b2b accepted", 32'(idx), 32'd4);
    chk("b2b overlap", 32'(overlap), 32'd0);
    chk("b2b paddr", 32'(bad_addr), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_apb_manager

// File: doc/apb_manager.md
APB_MANAGER -- requirements
Module: apb_manager

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, APB data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, APB address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase cycles before abort; legal range 2..255.
REQ-004 SHALL have one clock and an asynchronous active-low reset: PCLK  in  1  clock; PRESETn  in  1  reset.
REQ-005 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted this cycle.
REQ-006 cmd_write  in  1  1=write, 0=read; cmd_addr  in  ADDR_WIDTH  target address; cmd_wdata  in  DATA_WIDTH  write data.
REQ-007 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  DATA_WIDTH  read data; rsp_err  out  1  PSLVERR or timeout.
REQ-008 PSELx  out  1  select; PENABLE  out  1  access phase; PWRITE  out  1  direction.
REQ-009 PADDR  out  ADDR_WIDTH  address; PWDATA  out  DATA_WIDTH  write data.
REQ-010 PRDATA  in  DATA_WIDTH  read data; PREADY  in  1  subordinate ready; PSLVERR  in  1  subordinate error.

Function
REQ-011 SHALL implement the states IDLE, SETUP and ACCESS.
REQ-012 SHALL drive cmd_ready=1 only in IDLE, decoded combinationally from state.
REQ-013 On a cmd_valid&&cmd_ready edge: register PADDR, PWRITE and PWDATA; next state SETUP with PSELx=1, PENABLE=0.
REQ-014 SETUP SHALL last exactly one cycle, then go to ACCESS with PSELx=1, PENABLE=1; PREADY is ignored in SETUP.
REQ-015 In ACCESS with PREADY=1: next edge returns to IDLE, PSELx=PENABLE=0, rsp_valid=1 for one cycle, and rsp_err=PSLVERR.
REQ-016 In ACCESS with PREADY=1: rsp_rdata SHALL be PRDATA for reads and 0 for writes.
REQ-017 Minimum latency: handshake at edge N gives SETUP in cycle N+1, ACCESS in N+2, and rsp_valid plus cmd_ready high in N+3.
REQ-018 SHALL count ACCESS cycles with PREADY=0 (width $clog2(TIMEOUT+1)), cleared on entry to ACCESS.
REQ-019 When TIMEOUT ACCESS cycles have elapsed with PREADY=0: abort to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-020 If PREADY=1 arrives in the same cycle the counter expires, SHALL complete normally (PREADY wins).
REQ-021 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS, and SHALL hold their last values in IDLE.
REQ-022 rsp_valid SHALL have no backpressure; rsp_rdata and rsp_err SHALL hold until the next completion.
REQ-023 cmd_* inputs outside a handshake SHALL have no effect; back-to-back commands are separated by at least one IDLE cycle.

Reset
REQ-024 PRESETn low SHALL asynchronously force state IDLE, counter 0, and every output 0 except cmd_ready, which is 1 (IDLE).
REQ-025 Reset during SETUP or ACCESS SHALL drop PSELx and PENABLE immediately and SHALL issue no rsp_valid for the aborted transfer.

Structure
REQ-026 Package apb_pkg SHALL hold the apb_state_e enum (IDLE, SETUP, ACCESS) and the default DATA_WIDTH and ADDR_WIDTH constants shared with apb_subordinate.
REQ-027 The wait counter and expiry compare SHALL be a sub-module apb_wait_timer (inputs clear and enable, output expired).

Verification
REQ-028 Write addr 0x155, data 0xA5, PREADY tied 1 -> PSELx high 2 cycles, PENABLE high 1 cycle, rsp_valid at N+3, rsp_err=0.
REQ-029 Read addr 0x3FF, subordinate returns 0x5A after 3 wait cycles -> rsp_rdata=0x5A, rsp_valid at N+6, PADDR stable throughout.
REQ-030 Write with PSLVERR=1 at the PREADY cycle -> rsp_err=1, return to IDLE, cmd_ready=1 the next cycle.
REQ-031 PREADY held 0 with TIMEOUT=16 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, PSELx=0.
REQ-032 PRESETn pulsed low during ACCESS of a read -> PSELx and PENABLE drop asynchronously, no rsp_valid, next command completes normally.
REQ-033 cmd_valid held high for 4 commands -> each accepted only in IDLE, 4 rsp_valid pulses in order, no overlapping PSELx.
